// File: rtl/key_debounce_decode.sv
// rtl/key_debounce_decode.sv - 4x4 keypad frame decoder with press/release debounce and key events
// Auto-repeat of the held key is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_decode #(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int CNT_W           = 4,
    parameter int REPEAT_FRAMES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_drv,
    input  logic [3:0] col_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       multi_key
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_PRESSED,
        S_RELEASE_DB
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

    // Empty on purpose: a legal parameter set never elaborates this block.
    if (DEBOUNCE_FRAMES < 2 || DEBOUNCE_FRAMES > 15 || REPEAT_FRAMES < 2) begin : g_illegal_params
    end

    logic [1:0] acc_keys_q;
    logic [3:0] acc_code_q;
    logic       acc_bad_q;

    logic       row_ok;
    logic [1:0] row_idx;
    logic [2:0] col_zeros;
    logic [1:0] col_idx;
    logic [1:0] smp_keys;
    logic [2:0] key_sum;
    logic [1:0] tot_keys;
    logic [3:0] tot_code;
    logic       tot_bad;
    logic       frame_end;
    logic       fr_empty;
    logic       fr_single;
    logic       fr_multi;

    // Key count saturates at 2, which is all MULTI needs to know.
    always_comb begin
        row_ok  = 1'b1;
        row_idx = 2'd0;
        case (row_drv)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
        col_zeros = 3'd0;
        col_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!col_in[i]) begin
                col_zeros = col_zeros + 3'd1;
                col_idx   = 2'(i);
            end
        end
        if (!row_ok || col_zeros == 3'd0) begin
            smp_keys = 2'd0;
        end else if (col_zeros == 3'd1) begin
            smp_keys = 2'd1;
        end else begin
            smp_keys = 2'd2;
        end
        key_sum   = {1'b0, acc_keys_q} + {1'b0, smp_keys};
        tot_keys  = (key_sum >= 3'd2) ? 2'd2 : key_sum[1:0];
        tot_code  = (acc_keys_q == 2'd0) ? {row_idx, col_idx} : acc_code_q;
        tot_bad   = acc_bad_q | ~row_ok;
        frame_end = (row_drv == 4'b0111);
        fr_empty  = tot_bad || (tot_keys == 2'd0);
        fr_single = !tot_bad && (tot_keys == 2'd1);
        fr_multi  = !tot_bad && (tot_keys == 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_keys_q <= 2'd0;
            acc_code_q <= 4'd0;
            acc_bad_q  <= 1'b0;
        end else if (frame_end) begin
            acc_keys_q <= 2'd0;
            acc_code_q <= 4'd0;
            acc_bad_q  <= 1'b0;
        end else begin
            acc_keys_q <= tot_keys;
            acc_code_q <= tot_code;
            acc_bad_q  <= tot_bad;
        end
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             down_q, down_d;
    logic             multi_q, multi_d;
`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_FRAMES - 1);
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;
        multi_d = multi_q;
`ifdef KEY_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        if (frame_end) begin
            multi_d = fr_multi;
            case (state_q)
                S_IDLE: begin
                    if (fr_single) begin
                        cand_d  = tot_code;
                        cnt_d   = CNT_ONE;
                        state_d = S_PRESS_DB;
                    end
                end
                S_PRESS_DB: begin
                    if (fr_single && tot_code == cand_q) begin
                        if (cnt_q == DB_LAST) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_PRESSED;
`ifdef KEY_AUTOREPEAT_EN
                            rpt_d   = '0;
`endif
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (fr_single) begin
                        cand_d = tot_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (fr_empty) begin
                        cnt_d   = CNT_ONE;
                        state_d = S_RELEASE_DB;
                    end else begin
                        cnt_d = '0;
`ifdef KEY_AUTOREPEAT_EN
                        if (fr_single && tot_code == code_q) begin
                            if (rpt_q == RPT_LAST) begin
                                valid_d = 1'b1;
                                rpt_d   = '0;
                            end else begin
                                rpt_d = rpt_q + 1'b1;
                            end
                        end else begin
                            rpt_d = '0;
                        end
`endif
                    end
                end
                S_RELEASE_DB: begin
                    if (fr_empty) begin
                        if (cnt_q == DB_LAST) begin
                            down_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_PRESSED;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_d   = '0;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
            multi_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
            multi_q <= multi_d;
`ifdef KEY_AUTOREPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;
    assign multi_key = multi_q;

endmodule

// File: tb/tb_key_debounce_decode.sv
// tb/tb_key_debounce_decode.sv - self-checking bench for key_debounce_decode
// Frames are described as a 16-bit pressed-key mask (bit row*4+col) plus an invalid-row flag.
module tb_key_debounce_decode;

    localparam int DB  = 4;
    localparam int RPT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_drv;
    logic [3:0] col_in;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       multi_key;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_debounce_decode #(
        .DEBOUNCE_FRAMES(DB),
        .CNT_W          (4),
        .REPEAT_FRAMES  (RPT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_drv  (row_drv),
        .col_in   (col_in),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down),
        .multi_key(multi_key)
    );

    // Reference model: run lengths of qualifying frames rather than explicit states.
    bit         m_down;
    int         m_run;
    int         m_rel;
    int         m_rpt;
    logic [3:0] m_cand;
    logic [3:0] m_code;
    bit         m_multi;
    int         exp_pulses;

    int         obs_pulses;
    bit         obs_pulse_last;
    logic [3:0] obs_pulse_code;
    bit         obs_down;
    bit         obs_multi;
    logic [3:0] obs_code;

    task automatic model_reset();
        m_down = 0; m_run = 0; m_rel = 0; m_rpt = 0;
        m_cand = 4'd0; m_code = 4'd0; m_multi = 0;
    endtask

    task automatic model_frame(input logic [15:0] mask, input bit bad);
        int  n;
        int  k;
        bit  single;
        bit  empty;
        n = $countones(mask);
        k = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = i;
        single  = !bad && n == 1;
        empty   = bad || n == 0;
        m_multi = !bad && n > 1;
        exp_pulses = 0;
        if (!m_down) begin
            if (single) begin
                if (m_run > 0 && 4'(k) == m_cand) m_run++;
                else begin m_cand = 4'(k); m_run = 1; end
                if (m_run == DB) begin
                    m_down = 1; m_code = 4'(k); m_run = 0; m_rel = 0; m_rpt = 0;
                    exp_pulses = 1;
                end
            end else begin
                m_run = 0;
            end
        end else if (empty) begin
            m_rel++;
            if (m_rel == DB) begin m_down = 0; m_rel = 0; end
        end else if (m_rel > 0) begin
            m_rel = 0; m_rpt = 0;
        end else if (single && 4'(k) == m_code) begin
`ifdef KEY_AUTOREPEAT_EN
            m_rpt++;
            if (m_rpt == RPT) begin m_rpt = 0; exp_pulses = 1; end
`endif
        end else begin
            m_rpt = 0;
        end
    endtask

    // Drives one scan frame; an invalid frame gets an extra non-one-hot row cycle.
    task automatic run_frame(input logic [15:0] mask, input bit bad);
        int         nrows;
        int         r;
        logic [3:0] one;
        logic [15:0] mk;
        one = 4'b0001;
        mk = mask;
        nrows = bad ? 5 : 4;
        obs_pulses = 0;
        obs_pulse_last = 0;
        obs_pulse_code = 4'd0;
        for (int c = 0; c < nrows; c++) begin
            if (bad && c == 1) begin
                row_drv = 4'b1001;
                col_in  = 4'(~mk[7:4]);
            end else begin
                r = (bad && c > 1) ? c - 1 : c;
                row_drv = ~(one << r);
                col_in  = ~mk[r*4 +: 4];
            end
            @(posedge clk);
            #1;
            if (key_valid) begin
                obs_pulses++;
                obs_pulse_code = key_code;
                if (c == nrows - 1) obs_pulse_last = 1;
            end
        end
        obs_down  = key_down;
        obs_code  = key_code;
        obs_multi = multi_key;
        model_frame(mask, bad);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        row_drv = 4'b1111;
        col_in = 4'b1111;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (key_code !== 4'd0) begin n_bad++; $display("FAIL reset_code got %h want 0", key_code); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", key_valid); end
        n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL reset_down got %b want 0", key_down); end
        n_cmp++; if (multi_key !== 1'b0) begin n_bad++; $display("FAIL reset_multi got %b want 0", multi_key); end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        int total;
        total = 0;
        for (int f = 1; f <= 4; f++) begin
            run_frame(16'h0008, 0);
            total += obs_pulses;
            if (f < 4) begin
                n_cmp++; if (obs_pulses !== 0) begin n_bad++; $display("FAIL clean_early frame %0d pulses %0d want 0", f, obs_pulses); end
            end
        end
        n_cmp++; if (total !== 1) begin n_bad++; $display("FAIL clean_pulses got %0d want 1", total); end
        n_cmp++; if (obs_pulse_last !== 1'b1) begin n_bad++; $display("FAIL clean_latency got %b want 1", obs_pulse_last); end
        n_cmp++; if (obs_pulse_code !== 4'h3) begin n_bad++; $display("FAIL clean_code got %h want 3", obs_pulse_code); end
        n_cmp++; if (obs_down !== 1'b1) begin n_bad++; $display("FAIL clean_down got %b want 1", obs_down); end
        for (int f = 0; f < 4; f++) run_frame(16'h0000, 0);
        n_cmp++; if (obs_down !== 1'b0) begin n_bad++; $display("FAIL clean_release got %b want 0", obs_down); end
        n_cmp++; if (obs_code !== 4'h3) begin n_bad++; $display("FAIL clean_code_hold got %h want 3", obs_code); end
    endtask

    task automatic test_bounce();
        bit present [7] = '{1, 1, 0, 1, 1, 1, 1};
        for (int f = 0; f < 7; f++) begin
            run_frame(present[f] ? 16'h0200 : 16'h0000, 0);
            n_cmp++;
            if (obs_pulses !== (f == 6 ? 1 : 0)) begin
                n_bad++; $display("FAIL bounce_pulse frame %0d got %0d want %0d", f + 1, obs_pulses, (f == 6 ? 1 : 0));
            end
        end
        n_cmp++; if (obs_pulse_code !== 4'h9) begin n_bad++; $display("FAIL bounce_code got %h want 9", obs_pulse_code); end
        for (int f = 0; f < 4; f++) run_frame(16'h0000, 0);
    endtask

    task automatic test_release();
        for (int f = 0; f < 4; f++) run_frame(16'h0040, 0);
        for (int f = 0; f < 3; f++) begin
            run_frame(16'h0000, 0);
            n_cmp++; if (obs_down !== 1'b1) begin n_bad++; $display("FAIL release_glitch empty %0d down %b want 1", f + 1, obs_down); end
        end
        run_frame(16'h0040, 0);
        n_cmp++; if (obs_down !== 1'b1 || obs_pulses !== 0) begin n_bad++; $display("FAIL release_repress down %b pulses %0d want 1/0", obs_down, obs_pulses); end
        for (int f = 1; f <= 4; f++) begin
            run_frame(16'h0000, 0);
            n_cmp++;
            if (obs_down !== (f < 4)) begin n_bad++; $display("FAIL release_drop empty %0d down %b want %b", f, obs_down, (f < 4)); end
        end
    endtask

    task automatic test_multi();
        int total;
        total = 0;
        for (int f = 0; f < 6; f++) begin
            run_frame(16'h4010, 0);
            total += obs_pulses;
        end
        n_cmp++; if (total !== 0) begin n_bad++; $display("FAIL multi_pulses got %0d want 0", total); end
        n_cmp++; if (obs_multi !== 1'b1) begin n_bad++; $display("FAIL multi_flag got %b want 1", obs_multi); end
        run_frame(16'h0000, 0);
        n_cmp++; if (obs_multi !== 1'b0) begin n_bad++; $display("FAIL multi_clear got %b want 0", obs_multi); end
        for (int f = 0; f < 4; f++) run_frame(16'h0020, 0);
        n_cmp++; if (obs_pulses !== 1 || obs_pulse_code !== 4'h5) begin n_bad++; $display("FAIL change_first pulses %0d code %h want 1/5", obs_pulses, obs_pulse_code); end
        total = 0;
        for (int f = 0; f < 6; f++) begin
            run_frame(16'h0400, 0);
            total += obs_pulses;
        end
        n_cmp++; if (total !== 0) begin n_bad++; $display("FAIL change_pulses got %0d want 0", total); end
        n_cmp++; if (obs_code !== 4'h5 || obs_down !== 1'b1) begin n_bad++; $display("FAIL change_code code %h down %b want 5/1", obs_code, obs_down); end
        for (int f = 0; f < 4; f++) run_frame(16'h0000, 0);
    endtask

    task automatic test_reset_mid_press();
        for (int f = 0; f < 4; f++) run_frame(16'h0008, 0);
        n_cmp++; if (obs_down !== 1'b1) begin n_bad++; $display("FAIL midrst_pre down %b want 1", obs_down); end
        row_drv = 4'b1111;
        col_in = 4'b1111;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (key_down !== 1'b0 || key_code !== 4'd0 || key_valid !== 1'b0 || multi_key !== 1'b0) begin
            n_bad++; $display("FAIL midrst_async down %b code %h valid %b multi %b want 0/0/0/0", key_down, key_code, key_valid, multi_key);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int f = 1; f <= 4; f++) begin
            run_frame(16'h0008, 0);
            n_cmp++;
            if (obs_pulses !== (f == 4 ? 1 : 0)) begin n_bad++; $display("FAIL midrst_repress frame %0d pulses %0d want %0d", f, obs_pulses, (f == 4 ? 1 : 0)); end
        end
        for (int f = 0; f < 4; f++) run_frame(16'h0000, 0);
    endtask

    task automatic test_autorepeat();
        int got [$];
        int want [$];
`ifdef KEY_AUTOREPEAT_EN
        want = '{4, 20, 36};
`else
        want = '{4};
`endif
        for (int f = 1; f <= 44; f++) begin
            run_frame(16'h8000, 0);
            if (obs_pulses > 0) begin
                got.push_back(f);
                n_cmp++; if (obs_pulse_code !== 4'hF) begin n_bad++; $display("FAIL repeat_code frame %0d got %h want f", f, obs_pulse_code); end
            end
        end
        n_cmp++;
        if (got.size() != want.size()) begin
            n_bad++; $display("FAIL repeat_count got %0d want %0d", got.size(), want.size());
        end else begin
            foreach (want[i]) begin
                n_cmp++; if (got[i] != want[i]) begin n_bad++; $display("FAIL repeat_frame got %0d want %0d", got[i], want[i]); end
            end
        end
        for (int f = 0; f < 4; f++) run_frame(16'h0000, 0);
    endtask

    task automatic test_random();
        int          seg_left;
        int          sel;
        int          a;
        int          b;
        logic [15:0] one;
        logic [15:0] seg_mask;
        bit          seg_bad;
        one = 16'h0001;
        seg_left = 0;
        seg_mask = 16'h0;
        seg_bad = 0;
        for (int f = 0; f < 400; f++) begin
            if (seg_left == 0) begin
                sel = $urandom_range(0, 9);
                seg_left = $urandom_range(1, 8);
                seg_bad = 0;
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                if (sel < 3) seg_mask = 16'h0;
                else if (sel < 8) seg_mask = one << a;
                else if (sel == 8) seg_mask = (one << a) | (one << b);
                else begin seg_bad = 1; seg_mask = one << a; seg_left = $urandom_range(1, 2); end
            end
            run_frame(seg_mask, seg_bad);
            seg_left--;
            n_cmp++;
            if (obs_pulses !== exp_pulses || (exp_pulses == 1 && (!obs_pulse_last || obs_pulse_code !== m_code))) begin
                n_bad++; $display("FAIL rand_pulse frame %0d pulses %0d code %h want %0d code %h", f, obs_pulses, obs_pulse_code, exp_pulses, m_code);
            end
            n_cmp++;
            if (obs_down !== m_down || obs_code !== m_code || obs_multi !== m_multi) begin
                n_bad++; $display("FAIL rand_state frame %0d down %b code %h multi %b want %b %h %b", f, obs_down, obs_code, obs_multi, m_down, m_code, m_multi);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_multi();
        test_reset_mid_press();
        test_autorepeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
